ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Sits between two memory requesters and the single-port-write data RAM:
  - requester 0: CPU load/store unit
  - requester 1: auxiliary master (program loader / debug)
- Arbitrates between them, registers the selected command and drives the RAM port signals. It sequences the RAM's one-cycle registered read and returns the response to the owning requester.
- Rejects accesses the RAM cannot perform (misaligned, out of range, bad mode) with an error response, without touching the RAM.

Parameters:
- MEM_WORDS, 24576: RAM depth in 32-bit words. Valid byte addresses are 0 .. 4*MEM_WORDS-1.
- STARVE_LIMIT, 4: consecutive cycles requester 1 may be denied while valid before it is forced a grant.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready = handshake)
- req0_we / req1_we  in  1  1 = store, 0 = load
- req0_addr / req1_addr  in  32  byte address
- req0_wdata / req1_wdata  in  32  store data, low bits used for byte/half
- req0_mode / req1_mode  in  2  0 byte, 1 half, 2 word, 3 invalid
- req0_signed / req1_signed  in  1  sign-extend load
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  32  load data; 0 for stores and errors
- rsp0_err / rsp1_err  out  1  access rejected
- ram_we  out  1
- ram_r_addr, ram_w_addr  out  32
- ram_w_data  out  32
- ram_write_mode, ram_read_mode  out  2
- ram_read_signed  out  1
- ram_r_data  in  32  registered RAM read data

Behaviour:
- Reset values (async on rst high):
  - state = IDLE
  - all outputs 0, including ram_we, rsp*_valid, rsp*_err and ram address/data/mode outputs
  - starvation counter = 0
- Reset during any state drops the in-flight access; no response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req*_ready is asserted only in IDLE, and only to the granted requester; never to both.
  - Grant rule: requester 0 wins, except when the starvation counter equals STARVE_LIMIT and req1_valid is high, in which case requester 1 wins.
  - Counter increments each cycle req1_valid=1 and requester 1 loses.
  - Counter clears on any requester-1 grant, or when req1_valid=0.
  - On handshake, capture owner id, we, addr, wdata, mode and signed into command registers.
  - Check the captured command. It is bad if any of:
    - mode==3
    - half with addr[1:0]==3
    - word with addr[1:0]!=0
    - addr >= 4*MEM_WORDS
  - Next state: bad -> RESP with err=1; otherwise -> ISSUE.
- ISSUE (one cycle):
  - Drive ram_r_addr = ram_w_addr = cmd addr, ram_w_data = cmd wdata, ram_write_mode = ram_read_mode = cmd mode, ram_read_signed = cmd signed, ram_we = cmd we.
  - Store -> RESP. Load -> WAIT.
- WAIT (one cycle):
  - ram_we=0; RAM address/mode held.
  - Assert rsp<owner>_valid=1 with rdata = ram_r_data, err=0.
  - -> IDLE.
- RESP (one cycle):
  - Assert rsp<owner>_valid=1 with rdata=0 and err set per check.
  - -> IDLE.
- ram_we is high only in ISSUE of a store; at most one write per accepted request.
- Latency, handshake at cycle T:
  - load response at T+2
  - store response at T+2
  - error response at T+1
- Next accept is possible in the cycle the response pulses plus one, i.e. T+3 for load/store and T+2 for an error.
- The non-owner's rsp_valid stays 0. Responses are never issued without a prior handshake.
- Simultaneous req0 and req1 in IDLE: exactly one ready. The loser keeps valid, and its payload must stay stable until accepted.

Decomposition:
- Shared package / define file holds:
  - RAM_MODE_BYTE=0, RAM_MODE_HALF=1, RAM_MODE_WORD=2
  - state encodings IDLE/ISSUE/WAIT/RESP
  - requester id constants REQ_CPU=0, REQ_AUX=1
- One sub-module: ram_access_check, purely combinational (addr, mode -> err), reusable by other memory masters.

Test Plan:
- Word store then load, req0: store addr 0x10 data 0xDEADBEEF, then load word 0x10.
  - Expect ram_we pulse one cycle with w_addr=0x10.
  - Load response at T+2 with rdata=0xDEADBEEF, err=0.
- Byte and half sign/zero extension, word 0x10=0x80FF7F01:
  - byte signed @0x12 -> 0xFFFFFFFF
  - byte unsigned @0x13 -> 0x00000080
  - half signed @0x12 -> 0xFFFF80FF
- Misaligned and invalid requests, no ram_we anywhere and rsp_err=1 at T+1 with rdata=0:
  - half @0x13
  - word @0x12
  - mode=3
  - addr 0x18000 (= 4*24576)
- Contention: both valid continuously.
  - req0 granted on the first 4 arbitration cycles where req1 was valid and lost; the 5th arbitration grants req1.
  - The counter then resets.
  - Never both ready in the same cycle.
- Response routing: req1 load while req0 idle.
  - Only rsp1_valid pulses; rsp0_valid stays 0 throughout.
- Reset mid-op: assert rst in the WAIT state of a load.
  - All outputs go to 0 immediately.
  - No rsp_valid after rst deasserts.
  - Next request is accepted normally in IDLE.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter and other masters of the same RAM:
// access modes, arbiter states, requester ids and the registered command format.
package ram_arbiter_pkg;

  // RAM access width encodings, shared with the RAM's read/write mode ports.
  localparam logic [1:0] RAM_MODE_BYTE = 2'd0;
  localparam logic [1:0] RAM_MODE_HALF = 2'd1;
  localparam logic [1:0] RAM_MODE_WORD = 2'd2;
  localparam logic [1:0] RAM_MODE_BAD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_t;

  // One accepted memory command, as registered toward the RAM.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mode;
    logic        sext;
  } ram_cmd_t;

endpackage

// File: rtl/ram_access_check.sv
// Combinational legality check for one RAM access: flags invalid modes,
// misaligned halves/words and addresses past the end of the RAM.
module ram_access_check
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = 24576
) (
  input  logic [31:0] addr,
  input  logic [1:0]  mode,
  output logic        err
);

  // One bit wider than the address so a full 4 GiB RAM would still compare correctly.
  localparam logic [32:0] ADDR_LIMIT = {1'b0, 32'(MEM_WORDS)} << 2;

  // Any single failing rule rejects the access.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    err = 1'b0;
    if (mode == RAM_MODE_BAD)                           err = 1'b1;
    // A half may start at offset 1 (bytes 1..2) but not cross into the next word.
    if (mode == RAM_MODE_HALF && addr[1:0] == 2'b11)    err = 1'b1;
    if (mode == RAM_MODE_WORD && addr[1:0] != 2'b00)    err = 1'b1;
    if ({1'b0, addr} >= ADDR_LIMIT)                     err = 1'b1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of the data RAM. The CPU has priority; the
// auxiliary master is forced through after STARVE_LIMIT lost arbitrations.
// Illegal accesses are answered with an error and never reach the RAM.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_WORDS    = 24576,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [1:0]  req0_mode,
  input  logic        req0_signed,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [1:0]  req1_mode,
  input  logic        req1_signed,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic        ram_we,
  output logic [31:0] ram_r_addr,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_data,
  output logic [1:0]  ram_write_mode,
  output logic [1:0]  ram_read_mode,
  output logic        ram_read_signed,
  input  logic [31:0] ram_r_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  arb_state_t    state;
  req_id_t       owner;
  ram_cmd_t      cmd;
  logic          ram_we_q;
  logic [1:0]    rsp_valid_q;
  logic          rsp_err_q;
  logic          rsp_load_q;
  logic [CW-1:0] starve_cnt;

  logic          force_aux;
  logic          grant_cpu;
  logic          grant_aux;
  logic          accept;
  req_id_t       grant_id;
  ram_cmd_t      sel_cmd;
  logic          sel_err;

  // Grant decision and payload select for the requester that wins this cycle.
  always_comb begin
    force_aux = req1_valid && (starve_cnt == STARVE_MAX);
    grant_aux = (state == IDLE) && req1_valid && (force_aux || !req0_valid);
    grant_cpu = (state == IDLE) && req0_valid && !force_aux;
    accept    = grant_cpu || grant_aux;
    grant_id  = grant_aux ? REQ_AUX : REQ_CPU;
    if (grant_aux) begin
      sel_cmd = '{we: req1_we, addr: req1_addr, wdata: req1_wdata,
                  mode: req1_mode, sext: req1_signed};
    end else begin
      sel_cmd = '{we: req0_we, addr: req0_addr, wdata: req0_wdata,
                  mode: req0_mode, sext: req0_signed};
    end
  end

  // The winner's payload is checked on the way in so errors answer one cycle later.
  ram_access_check #(
    .MEM_WORDS (MEM_WORDS)
  ) u_check (
    .addr (sel_cmd.addr),
    .mode (sel_cmd.mode),
    .err  (sel_err)
  );

  // Count arbitrations the auxiliary master loses while it keeps asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!req1_valid) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_aux)                    starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Access sequencer with registered RAM controls and response strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= REQ_CPU;
      cmd         <= '0;
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant_id;
            if (sel_err) begin
              // The RAM-facing command is left untouched for rejected accesses.
              state       <= RESP;
              rsp_valid_q <= (grant_id == REQ_AUX) ? 2'b10 : 2'b01;
              rsp_err_q   <= 1'b1;
            end else begin
              state    <= ISSUE;
              cmd      <= sel_cmd;
              ram_we_q <= sel_cmd.we;
            end
          end
        end
        ISSUE: begin
          rsp_valid_q <= (owner == REQ_AUX) ? 2'b10 : 2'b01;
          if (cmd.we) begin
            state <= RESP;
          end else begin
            state      <= WAIT;
            rsp_load_q <= 1'b1;
          end
        end
        WAIT:    state <= IDLE;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is combinational so the loser sees the decision in the same cycle.
  assign req0_ready = grant_cpu && !rst;
  assign req1_ready = grant_aux && !rst;

  assign ram_we          = ram_we_q;
  assign ram_r_addr      = cmd.addr;
  assign ram_w_addr      = cmd.addr;
  assign ram_w_data      = cmd.wdata;
  assign ram_write_mode  = cmd.mode;
  assign ram_read_mode   = cmd.mode;
  assign ram_read_signed = cmd.sext;

  // Load data is the RAM's own registered output, passed straight through in WAIT.
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_valid_q[0] && rsp_err_q;
  assign rsp1_err   = rsp_valid_q[1] && rsp_err_q;
  assign rsp0_rdata = (rsp_valid_q[0] && rsp_load_q) ? ram_r_data : 32'h0;
  assign rsp1_rdata = (rsp_valid_q[1] && rsp_load_q) ? ram_r_data : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a word-array RAM model behind the DUT,
// and a byte-level reference memory that predicts every response.
module tb_ram_arbiter;

  localparam int MEM_WORDS    = 24576;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_signed;
  logic [31:0] req0_addr, req0_wdata;
  logic [1:0]  req0_mode;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_signed;
  logic [31:0] req1_addr, req1_wdata;
  logic [1:0]  req1_mode;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        ram_we, ram_read_signed;
  logic [31:0] ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;
  logic [1:0]  ram_write_mode, ram_read_mode;

  ram_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_mode(req0_mode),
    .req0_signed(req0_signed), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_mode(req1_mode),
    .req1_signed(req1_signed), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_write_mode(ram_write_mode),
    .ram_read_mode(ram_read_mode), .ram_read_signed(ram_read_signed),
    .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ram_wr_count   = 0;
  int both_ready_cnt = 0;

  // ---------------- RAM model (word array, lane masks) ----------------
  logic [31:0] ram_words [0:MEM_WORDS-1];

  function automatic logic [31:0] ram_read_fn(input logic [31:0] a, input logic [1:0] m,
                                              input logic s);
    logic [31:0] w, sh;
    if (a >= 32'(4 * MEM_WORDS)) return 32'h0;
    w  = ram_words[a[16:2]];
    sh = w >> (8 * a[1:0]);
    case (m)
      2'd0:    return s ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'd1:    return s ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ram_merge(input logic [31:0] a, input logic [1:0] m,
                                            input logic [31:0] d);
    logic [31:0] old, mask;
    old = ram_words[a[16:2]];
    case (m)
      2'd0:    mask = 32'h0000_00FF << (8 * a[1:0]);
      2'd1:    mask = 32'h0000_FFFF << (8 * a[1:0]);
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | ((d << (8 * a[1:0])) & mask);
  endfunction

  always @(posedge clk) begin
    ram_r_data <= ram_read_fn(ram_r_addr, ram_read_mode, ram_read_signed);
    if (ram_we) begin
      ram_wr_count <= ram_wr_count + 1;
      if (ram_w_addr < 32'(4 * MEM_WORDS))
        ram_words[ram_w_addr[16:2]] <= ram_merge(ram_w_addr, ram_write_mode, ram_w_data);
    end
  end

  always @(negedge clk) begin
    if (req0_ready && req1_ready) both_ready_cnt <= both_ready_cnt + 1;
  end

  // ---------------- reference model (byte-addressed memory) ----------------
  logic [7:0] ref_mem [int unsigned];

  function automatic int nbytes(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] m);
    if (m == 2'd3) return 1'b1;
    if (a >= 32'(4 * MEM_WORDS)) return 1'b1;
    if (m == 2'd2 && (a % 4) != 0) return 1'b1;
    if (m == 2'd1 && (a % 4) == 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] m,
                                           input logic s);
    longint v = 0;
    int n = nbytes(m);
    for (int i = 0; i < n; i++) begin
      int unsigned k = a + i;
      if (ref_mem.exists(k)) v += longint'(ref_mem[k]) << (8 * i);
    end
    if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    for (int i = 0; i < nbytes(m); i++) ref_mem[a + i] = 8'(d >> (8 * i));
  endtask

  // ---------------- checking and driving ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input bit v, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] mode, input bit sgn);
    if (id) begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
      req1_mode = mode; req1_signed = sgn;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
      req0_mode = mode; req0_signed = sgn;
    end
  endtask

  // One complete request: handshake, response timing/routing, RAM side effects.
  task automatic txn(input bit id, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] mode, input bit sgn,
                     output logic [31:0] rdata_obs);
    bit          exp_err, got, wr_exp;
    logic [31:0] exp_rdata;
    int          lat, wr0;
    exp_err   = ref_bad(addr, mode);
    exp_rdata = (exp_err || we) ? 32'h0 : ref_load(addr, mode, sgn);
    lat       = exp_err ? 1 : 2;
    wr_exp    = !exp_err && we;
    rdata_obs = 32'h0;
    @(posedge clk); #1;
    drive(id, 1'b1, we, addr, wdata, mode, sgn);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    check("accept", 32'(got), 32'd1);
    wr0 = ram_wr_count;
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    if (!got) return;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("rsp_valid", 32'(id ? rsp1_valid : rsp0_valid), 32'(c == lat));
      check("other_rsp_valid", 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
      if (c == 1) begin
        check("ram_we_issue", 32'(ram_we), 32'(wr_exp));
        if (wr_exp) check("ram_w_addr", ram_w_addr, addr);
      end else begin
        check("ram_we_after", 32'(ram_we), 32'd0);
      end
      if (c == lat) begin
        rdata_obs = id ? rsp1_rdata : rsp0_rdata;
        check("rsp_rdata", rdata_obs, exp_rdata);
        check("rsp_err", 32'(id ? rsp1_err : rsp0_err), 32'(exp_err));
      end
    end
    check("ram_writes", 32'(ram_wr_count - wr0), 32'(wr_exp));
    if (wr_exp) ref_store(addr, mode, wdata);
  endtask

  initial begin
    logic [31:0] rd;
    int losses, grants_aux, last_grant, cyc;
    bit got_any;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // Reset state, with a request already pending.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    @(negedge clk); @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_r_addr", ram_r_addr, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    rst = 1'b0;

    // Prefill the region used by the random phase so both memories agree.
    for (int a = 0; a < 64; a += 4) txn(1'b0, 1'b1, 32'(a), $urandom, 2'd2, 1'b0, rd);
    txn(1'b1, 1'b1, 32'h17FFC, $urandom, 2'd2, 1'b0, rd);

    // Word store then load.
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);
    check("word_load_value", rd, 32'hDEADBEEF);

    // Sub-word extension.
    txn(1'b0, 1'b1, 32'h10, 32'h80FF7F01, 2'd2, 1'b0, rd);
    txn(1'b0, 1'b0, 32'h12, 32'h0, 2'd0, 1'b1, rd);
    check("byte_signed", rd, 32'hFFFFFFFF);
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, rd);
    check("byte_unsigned", rd, 32'h00000080);
    txn(1'b0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd);
    check("half_signed", rd, 32'hFFFF80FF);

    // Rejected accesses.
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'd1, 1'b0, rd);
    txn(1'b0, 1'b1, 32'h12, 32'h1234, 2'd2, 1'b0, rd);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, rd);
    txn(1'b0, 1'b1, 32'h18000, 32'h55, 2'd2, 1'b0, rd);
    txn(1'b1, 1'b1, 32'h17FFC, 32'hA5A5A5A5, 2'd2, 1'b0, rd);

    // Response routing to requester 1.
    txn(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);

    // After an error the next request is accepted two cycles after the handshake.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
    @(negedge clk);
    check("b2b_accept_err", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_mode = 2'd2;
    @(negedge clk);
    check("b2b_busy", 32'(req0_ready), 32'd0);
    check("b2b_err_rsp", 32'(rsp0_err), 32'd1);
    @(negedge clk);
    check("b2b_accept_next", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk); @(negedge clk);
    check("b2b_load_valid", 32'(rsp0_valid), 32'd1);
    check("b2b_load_data", rsp0_rdata, ref_load(32'h10, 2'd2, 1'b0));

    // Contention: both requesters hold valid loads continuously.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
    losses = 0; grants_aux = 0; last_grant = -1; cyc = 0;
    while (grants_aux < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      got_any = req0_ready || req1_ready;
      if (got_any) begin
        check("arb_grant_aux", 32'(req1_ready), 32'(losses == STARVE_LIMIT));
        if (last_grant >= 0) check("arb_gap", 32'(cyc - last_grant), 32'd3);
        last_grant = cyc;
        if (req1_ready) begin
          grants_aux++;
          losses = 0;
        end else begin
          losses++;
        end
      end
    end
    check("arb_aux_grants", 32'(grants_aux), 32'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    repeat (4) @(posedge clk);

    // Reset in the WAIT cycle of a load.
    #1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    check("midrst_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    @(posedge clk); #1;
    check("midrst_in_wait", 32'(rsp0_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("midrst_rsp0_rdata", rsp0_rdata, 32'h0);
    check("midrst_ram_r_addr", ram_r_addr, 32'h0);
    check("midrst_ram_mode", 32'(ram_read_mode), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);

    // Random traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [1:0]  m;
      int          r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h18000 + $urandom_range(0, 7);
      else if (r == 1) a = 32'h17FFC + $urandom_range(0, 3);
      else             a = $urandom_range(0, 63);
      m = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, m,
          1'($urandom_range(0, 1)), rd);
    end

    check("never_both_ready", 32'(both_ready_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
